ad738x_spi_frontend: RTL

- Parametrised successor to the team's single-purpose AD7383 interface: the SPI master for the AD738x family of simultaneous-sampling SAR ADCs.
- Generalised in lane count, sample width and SCLK divide; adds a configurable config value, bounded init retry with fault reporting, and a clean stop back to idle.
- Sits between ADC pins and the capture FIFO; runs in the dedicated ADC clock domain.

---
 rtl/ad738x_spi_frontend.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ad738x_spi_frontend.sv
// SPI master for AD738x simultaneous-sampling SAR ADCs: init/config/readback sequence,
// then continuous N_CH-lane capture with a fixed frame rate.
module ad738x_spi_frontend #(
  parameter int          N_CH       = 2,
  parameter int          DATA_W     = 16,
  parameter int          CLK_DIV    = 1,
  parameter int          FRAME_CLKS = 34,
  parameter logic [11:0] CFG1_VAL   = 12'h022,
  parameter int          MAX_RETRY  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     init_i,
  input  logic                     stop_i,
  output logic                     ready_o,
  output logic                     fault_o,
  output logic [N_CH*DATA_W-1:0]   data_o,
  output logic                     valid_o,
  input  logic [N_CH-1:0]          sdi_i,
  output logic                     cs_n_o,
  output logic                     sclk_o,
  output logic                     sdo_o
);

  localparam int BP  = 2 * CLK_DIV;
  localparam int ACT = BP * DATA_W;
  localparam int FW  = $clog2(FRAME_CLKS);
  localparam int PW  = $clog2(BP);
  localparam int BW  = $clog2(DATA_W + 1);

  if (FRAME_CLKS < ACT + 2) begin : g_frame_chk
    $error("FRAME_CLKS too short for one full command frame");
  end
  if (N_CH < 1 || N_CH > 4 || DATA_W < 12 || DATA_W > 32 || MAX_RETRY < 1 || MAX_RETRY > 15)
  begin : g_param_chk
    $error("ad738x_spi_frontend parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_CLEAR, S_CONFIG, S_READBACK, S_CHECK, S_SAMPLE, S_FAULT
  } state_t;

  state_t            state, nxt_state;
  logic [FW-1:0]     f, nxt_f;
  logic [PW-1:0]     ph, nxt_ph;
  logic [BW-1:0]     bitn, nxt_bit;
  logic [3:0]        retry, nxt_retry;
  logic [DATA_W-1:0] sh [N_CH];
  logic [N_CH*DATA_W-1:0] sh_flat;
  logic              halted, frame_end, nxt_act, nxt_sclk, cmd_bit, rb_ok, load, clear;
  logic [11:0]       rb_field;

  function automatic logic [15:0] cmd16(input state_t s);
    case (s)
      S_RESET:    cmd16 = 16'hA03C;
      S_CLEAR:    cmd16 = 16'hA000;
      S_CONFIG:   cmd16 = {4'h9, CFG1_VAL};
      S_READBACK: cmd16 = 16'h1000;
      default:    cmd16 = 16'h0000;
    endcase
  endfunction

  assign halted    = (state == S_IDLE) || (state == S_FAULT);
  assign frame_end = (f == FW'(FRAME_CLKS - 1));
  // Left-justify lane 0 in 32 bits so the register field sits at [27:16] for any DATA_W.
  assign rb_field  = 12'((32'(sh[0]) << (32 - DATA_W)) >> 16);
  assign rb_ok     = (rb_field == CFG1_VAL);

  always_comb begin
    nxt_state = state;
    nxt_retry = retry;
    case (state)
      S_IDLE:     if (init_i) nxt_state = S_RESET;
      S_FAULT:    if (init_i) begin
                    nxt_state = S_RESET;
                    nxt_retry = '0;
                  end
      S_RESET:    if (frame_end) nxt_state = S_CLEAR;
      S_CLEAR:    if (frame_end) nxt_state = S_CONFIG;
      S_CONFIG:   if (frame_end) nxt_state = S_READBACK;
      S_READBACK: if (frame_end) nxt_state = S_CHECK;
      S_CHECK:    if (frame_end) begin
                    if (rb_ok) begin
                      nxt_state = S_SAMPLE;
                      nxt_retry = '0;
                    end else begin
                      nxt_retry = retry + 4'd1;
                      nxt_state = (nxt_retry == 4'(MAX_RETRY)) ? S_FAULT : S_RESET;
                    end
                  end
      S_SAMPLE:   if (frame_end && stop_i) nxt_state = S_IDLE;
      default:    nxt_state = S_IDLE;
    endcase

    nxt_f   = '0;
    nxt_ph  = '0;
    nxt_bit = '0;
    if (!halted && !frame_end) begin
      nxt_f   = f + 1'b1;
      nxt_ph  = ph + 1'b1;
      nxt_bit = bitn;
      if (ph == PW'(BP - 1)) begin
        nxt_ph = '0;
        if (bitn != BW'(DATA_W)) nxt_bit = bitn + 1'b1;
      end
    end
  end

  // Pins are registered from the next-cycle frame position so they line up with f.
  assign nxt_act  = (nxt_state != S_IDLE) && (nxt_state != S_FAULT) && (nxt_f < FW'(ACT));
  assign nxt_sclk = !nxt_act || (nxt_ph >= PW'(CLK_DIV));
  assign cmd_bit  = 1'(({cmd16(nxt_state), 16'h0000} << nxt_bit) >> 31);
  assign load     = nxt_act && (nxt_ph == PW'(CLK_DIV));
  assign clear    = halted && (nxt_state == S_RESET);

  always_comb begin
    sh_flat = '0;
    for (int c = 0; c < N_CH; c++) sh_flat[c*DATA_W +: DATA_W] = sh[c];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      f       <= '0;
      ph      <= '0;
      bitn    <= '0;
      retry   <= '0;
      cs_n_o  <= 1'b1;
      sclk_o  <= 1'b1;
      sdo_o   <= 1'b0;
      valid_o <= 1'b0;
      ready_o <= 1'b0;
      fault_o <= 1'b0;
      data_o  <= '0;
      for (int c = 0; c < N_CH; c++) sh[c] <= '0;
    end else begin
      state   <= nxt_state;
      f       <= nxt_f;
      ph      <= nxt_ph;
      bitn    <= nxt_bit;
      retry   <= nxt_retry;
      cs_n_o  <= !nxt_act;
      sclk_o  <= nxt_sclk;
      sdo_o   <= nxt_act && cmd_bit;
      ready_o <= (nxt_state == S_SAMPLE);
      fault_o <= (nxt_state == S_FAULT);
      valid_o <= (state == S_SAMPLE) && (nxt_f == FW'(ACT));
      if ((state == S_SAMPLE) && (nxt_f == FW'(ACT))) data_o <= sh_flat;
      for (int c = 0; c < N_CH; c++) begin
        if (clear)     sh[c] <= '0;
        else if (load) sh[c] <= {sh[c][DATA_W-2:0], sdi_i[c]};
      end
    end
  end

endmodule
